// File: rtl/mean_square_window_if.sv
// Sample-in / mean-square-out bundle for mean_square_window.
// slave: design side; master: producer/consumer side.
interface mean_square_window_if #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 8
);
  logic              i_clear;
  logic              i_valid;
  logic [DATA_W-1:0] i_data;
  logic              i_ready;
  logic              o_valid;
  logic [OUT_W-1:0]  o_data;
  logic              o_overrun;

  modport master (
    output i_clear, i_valid, i_data, i_ready,
    input  o_valid, o_data, o_overrun
  );

  modport slave (
    input  i_clear, i_valid, i_data, i_ready,
    output o_valid, o_data, o_overrun
  );
endinterface

// File: rtl/mean_square_window.sv
// Squares signed samples, averages 2**LOG2_N of them, scales and
// saturates to OUT_W bits, and holds each result under valid/ready.
// Ports: i_clk, i_reset (async, high); bus carries i_clear, i_valid,
// i_data, i_ready in and o_valid, o_data, o_overrun out.
module mean_square_window #(
  parameter int DATA_W = 8,
  parameter int LOG2_N = 4,
  parameter int OUT_W  = 8
) (
  input logic               i_clk,
  input logic               i_reset,
  mean_square_window_if.slave bus
);
  localparam int SQ_W  = 2*DATA_W-1;
  localparam int ACC_W = SQ_W+LOG2_N;
  localparam int SH    = LOG2_N+2*DATA_W-2-OUT_W;
  localparam logic [ACC_W-1:0] MAX =
    {{(ACC_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

  typedef enum logic {EMPTY, FULL} state_t;

  logic              s1_v_q, s1_v_d;
  logic [SQ_W-1:0]   sq_q, sq_d;
  logic [LOG2_N-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              res_v_q, res_v_d;
  logic [OUT_W-1:0]  res_q, res_d;
  state_t            state_q, state_d;
  logic [OUT_W-1:0]  data_q, data_d;
  logic              ovr_q, ovr_d;

  logic signed [2*DATA_W-1:0] dx;
  logic [ACC_W-1:0]           total;
  logic [ACC_W-1:0]           mean;

  always_comb begin
    dx = {{DATA_W{bus.i_data[DATA_W-1]}}, bus.i_data};
    s1_v_d = bus.i_valid & ~bus.i_clear;
    sq_d = sq_q;
    if (bus.i_valid) begin
      // (-2**(DATA_W-1))**2 still fits SQ_W bits
      sq_d = SQ_W'(dx * dx);
    end
    total = acc_q + ACC_W'(sq_q);
    mean = total >> SH;
    cnt_d = cnt_q;
    acc_d = acc_q;
    res_v_d = 1'b0;
    res_d = res_q;
    if (bus.i_clear) begin
      cnt_d = '0;
      acc_d = '0;
    end else if (s1_v_q) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == '1) begin
        acc_d = '0;
        res_v_d = 1'b1;
        res_d = (mean > MAX) ? '1 : OUT_W'(mean);
      end else begin
        acc_d = total;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    data_d = data_q;
    ovr_d = 1'b0;
    case (state_q)
      EMPTY: begin
        if (res_v_q) begin
          state_d = FULL;
          data_d = res_q;
        end
      end
      FULL: begin
        if (res_v_q) begin
          data_d = res_q;
          ovr_d = ~bus.i_ready;
        end else if (bus.i_ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      s1_v_q  <= 1'b0;
      sq_q    <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      res_v_q <= 1'b0;
      res_q   <= '0;
      state_q <= EMPTY;
      data_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      s1_v_q  <= s1_v_d;
      sq_q    <= sq_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      res_v_q <= res_v_d;
      res_q   <= res_d;
      state_q <= state_d;
      data_q  <= data_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.o_valid   = (state_q == FULL);
  assign bus.o_data    = data_q;
  assign bus.o_overrun = ovr_q;
endmodule

// File: tb/tb_mean_square_window.sv
// Directed and reference-model bench for mean_square_window.
// Inputs change 1ns after the falling edge; outputs are read there.
module tb_mean_square_window;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   vcyc = 0;
  int   ovr = 0;
  int   v0;
  int   o0;

  mean_square_window_if #(.DATA_W(8), .OUT_W(8)) bus ();

  mean_square_window #(
    .DATA_W(8), .LOG2_N(4), .OUT_W(8)
  ) dut (
    .i_clk(clk),
    .i_reset(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.o_valid) vcyc++;
    if (bus.o_overrun) ovr++;
  end

  task automatic check(input string tag,
                       input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic v,
                     input logic signed [7:0] d,
                     input logic rdy, input logic clr);
    bus.i_valid = v;
    bus.i_data = d;
    bus.i_ready = rdy;
    bus.i_clear = clr;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic feed(input logic signed [7:0] d,
                      input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(1'b1, d, rdy, 1'b0);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'sd0, rdy, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0, 8'sd0, 1'b1, 1'b0);
    rst = 1'b0;
    #1;
  endtask

  function automatic int scale(input longint s);
    longint r;
    r = (s >> 4) >> 6;
    return (r > 255) ? 255 : int'(r);
  endfunction

  // reference model state for the random run
  int     m_cnt, p_d, md, s_sq, ld;
  longint m_sum;
  bit     s_v, p_v, mv, movr, land;

  initial begin
    bus.i_valid = 1'b0;
    bus.i_data = '0;
    bus.i_ready = 1'b1;
    bus.i_clear = 1'b0;
    #1;
    check("rst_valid", int'(bus.o_valid), 0);
    check("rst_data", int'(bus.o_data), 0);
    check("rst_ovr", int'(bus.o_overrun), 0);
    do_reset();

    // 16 x 64 -> 64, two edges after the last sample
    v0 = vcyc;
    feed(8'sd64, 16, 1'b1);
    check("t64_early0", int'(bus.o_valid), 0);
    idle(1, 1'b1);
    check("t64_early1", int'(bus.o_valid), 0);
    idle(1, 1'b1);
    check("t64_valid", int'(bus.o_valid), 1);
    check("t64_data", int'(bus.o_data), 64);
    idle(3, 1'b1);
    check("t64_once", vcyc - v0, 1);

    // 16 x -128 saturates
    feed(-8'sd128, 16, 1'b1);
    idle(2, 1'b1);
    check("sat_valid", int'(bus.o_valid), 1);
    check("sat_data", int'(bus.o_data), 255);
    idle(2, 1'b1);

    // alternating 0/32 with every 3rd cycle idle
    v0 = vcyc;
    begin
      int k;
      int s;
      k = 0;
      s = 0;
      while (s < 16) begin
        if (k % 3 == 2) begin
          cyc(1'b0, 8'sd0, 1'b1, 1'b0);
        end else begin
          cyc(1'b1, (s % 2) ? 8'sd32 : 8'sd0, 1'b1, 1'b0);
          s++;
        end
        k++;
      end
    end
    check("gap_none_yet", vcyc - v0, 0);
    idle(2, 1'b1);
    check("gap_data", int'(bus.o_data), 8);
    idle(3, 1'b1);
    check("gap_count", vcyc - v0, 1);

    // overrun: two windows of 16 with i_ready low
    o0 = ovr;
    feed(8'sd16, 16, 1'b0);
    idle(2, 1'b0);
    check("ovr_w1_valid", int'(bus.o_valid), 1);
    check("ovr_w1_data", int'(bus.o_data), 4);
    feed(8'sd16, 16, 1'b0);
    check("ovr_w1_hold", int'(bus.o_data), 4);
    check("ovr_none_yet", ovr - o0, 0);
    idle(2, 1'b0);
    check("ovr_pulse", int'(bus.o_overrun), 1);
    check("ovr_w2_valid", int'(bus.o_valid), 1);
    idle(1, 1'b0);
    check("ovr_pulse_end", int'(bus.o_overrun), 0);
    check("ovr_once", ovr - o0, 1);
    idle(1, 1'b1);
    check("ovr_drain", int'(bus.o_valid), 0);

    // reset mid-window discards partial sum
    v0 = vcyc;
    feed(8'sd100, 9, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", int'(bus.o_valid), 0);
    cyc(1'b0, 8'sd0, 1'b1, 1'b0);
    rst = 1'b0;
    #1;
    feed(8'sd10, 15, 1'b1);
    idle(3, 1'b1);
    check("mid_rst_early", vcyc - v0, 0);
    feed(8'sd10, 1, 1'b1);
    idle(2, 1'b1);
    check("mid_rst_data", int'(bus.o_data), 1);
    idle(2, 1'b1);
    check("mid_rst_count", vcyc - v0, 1);

    // same with i_clear; the 10th sample rides the clear edge
    v0 = vcyc;
    feed(8'sd100, 9, 1'b1);
    cyc(1'b1, 8'sd100, 1'b1, 1'b1);
    feed(8'sd10, 15, 1'b1);
    idle(3, 1'b1);
    check("mid_clr_early", vcyc - v0, 0);
    feed(8'sd10, 1, 1'b1);
    idle(2, 1'b1);
    check("mid_clr_data", int'(bus.o_data), 1);
    idle(2, 1'b1);
    check("mid_clr_count", vcyc - v0, 1);

    // random stimulus against the reference model
    do_reset();
    m_cnt = 0; m_sum = 0; s_v = 0; s_sq = 0;
    p_v = 0; p_d = 0; mv = 0; md = 0; movr = 0;
    for (int t = 0; t < 800; t++) begin
      logic v, rdy, clr;
      logic signed [7:0] d;
      int di;
      v = ($urandom_range(0, 3) != 0);
      d = 8'($urandom);
      if (t >= 400) d = d >>> 3;
      rdy = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 79) == 0);
      di = d;
      land = p_v;
      ld = p_d;
      p_v = 0;
      if (clr) begin
        m_cnt = 0;
        m_sum = 0;
        s_v = 0;
      end else begin
        if (s_v) begin
          m_sum += s_sq;
          m_cnt++;
          if (m_cnt == 16) begin
            p_v = 1;
            p_d = scale(m_sum);
            m_cnt = 0;
            m_sum = 0;
          end
        end
        s_v = v;
        s_sq = di * di;
      end
      if (land) begin
        movr = mv && !rdy;
        mv = 1;
        md = ld;
      end else begin
        movr = 0;
        if (mv && rdy) mv = 0;
      end
      cyc(v, d, rdy, clr);
      check("rnd_valid", int'(bus.o_valid), int'(mv));
      check("rnd_ovr", int'(bus.o_overrun), int'(movr));
      if (mv) check("rnd_data", int'(bus.o_data), md);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
